issue_pair: RTL and testbench

ISSUE_PAIR -- requirements
Module: issue_pair

---
 rtl/issue_pair.sv | 151 +++++++++++++++
 tb/tb_issue_pair.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/issue_pair.sv
// issue_pair: circular instruction queue feeding a dual-slot decode stage.
// Issues the head word to slot A and pairs the next word into slot B when safe.
module issue_pair #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_instr,
    output logic                    in_ready,
    input  logic                    stall,
    input  logic                    flush,
    output logic [DATA_WIDTH-1:0]   instrA,
    output logic [DATA_WIDTH-1:0]   instrB,
    output logic                    validA,
    output logic                    validB,
    output logic [$clog2(DEPTH):0]  occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    // Queue storage and bookkeeping
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wptr;
    logic [AW-1:0]         rptr;
    logic [AW-1:0]         rptr_next;
    logic [CW-1:0]         count;

    // Head pair as seen before this edge's push
    logic [DATA_WIDTH-1:0] h0;
    logic [DATA_WIDTH-1:0] h1;

    // Decode fields used by the pairing rules
    logic [6:0] op0;
    logic [6:0] op1;
    logic [4:0] rd0;
    logic [4:0] rs1_h1;
    logic [4:0] rs2_h1;

    logic is_ctl;
    logic writes_rd;
    logic raw_hazard;
    logic mem_conflict;
    logic split;
    logic have_one;
    logic have_two;
    logic can_pair;
    logic issue;
    logic push;
    logic [CW-1:0] pop_cnt;

    assign rptr_next = rptr + 1'b1;

    assign h0 = mem[rptr];
    assign h1 = mem[rptr_next];

    assign op0    = h0[6:0];
    assign op1    = h1[6:0];
    assign rd0    = h0[11:7];
    assign rs1_h1 = h1[19:15];
    assign rs2_h1 = h1[24:20];

    // Control transfers always issue alone so slot B never sits in a shadow.
    assign is_ctl = (op0 == OP_BRANCH) ||
                    (op0 == OP_JAL)    ||
                    (op0 == OP_JALR);

    // Branches and stores carry no destination; x0 writes are discarded.
    assign writes_rd = (op0 != OP_BRANCH) &&
                       (op0 != OP_STORE)  &&
                       (rd0 != 5'd0);

    // Source fields are compared whatever H1's format, erring on the safe side.
    assign raw_hazard = writes_rd &&
                        ((rs1_h1 == rd0) || (rs2_h1 == rd0));

    // Only one memory port downstream.
    assign mem_conflict = ((op0 == OP_LOAD) || (op0 == OP_STORE)) &&
                          ((op1 == OP_LOAD) || (op1 == OP_STORE));

    assign split = is_ctl || raw_hazard || mem_conflict;

    assign have_one = (count != '0);
    assign have_two = (count >= CW'(2));
    assign can_pair = have_two && !split;

    assign issue = !rst && !flush && !stall && have_one;

    assign pop_cnt = !issue   ? CW'(0) :
                     can_pair ? CW'(2) :
                                CW'(1);

    assign in_ready  = (count < CW'(DEPTH));
    assign push      = in_valid && in_ready && !flush && !rst;
    assign occupancy = count;

    // Write accepted fetch words into the slot at the write pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= in_instr;
        end
    end

    // Advance pointers and entry count; reset and flush empty the queue.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            rptr  <= rptr + AW'(pop_cnt);
            count <= count + CW'(push) - pop_cnt;
        end
    end

    // Register the decode slots; hold them while decode is stalled.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            instrA <= NOP;
            instrB <= NOP;
            validA <= 1'b0;
            validB <= 1'b0;
        end else if (!stall) begin
            if (!have_one) begin
                instrA <= NOP;
                instrB <= NOP;
                validA <= 1'b0;
                validB <= 1'b0;
            end else begin
                instrA <= h0;
                validA <= 1'b1;
                instrB <= can_pair ? h1 : NOP;
                validB <= can_pair;
            end
        end
    end

endmodule

// File: tb/tb_issue_pair.sv
// tb_issue_pair: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the issue rules.
module tb_issue_pair;

    localparam int DEPTH = 8;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        stall;
    logic        flush;
    logic [31:0] instrA;
    logic [31:0] instrB;
    logic        validA;
    logic        validB;
    logic [3:0]  occupancy;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mq[$];
    logic [31:0] ma;
    logic [31:0] mb;
    logic        mva;
    logic        mvb;

    issue_pair #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .stall(stall), .flush(flush),
        .instrA(instrA), .instrB(instrB),
        .validA(validA), .validB(validB),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic bit may_pair(input logic [31:0] a, input logic [31:0] b);
        logic [6:0] oa;
        logic [6:0] ob;
        logic [4:0] rd;
        bit ctl;
        bit dep;
        bit mm;
        oa = a[6:0];
        ob = b[6:0];
        rd = a[11:7];
        ctl = oa inside {7'h63, 7'h6f, 7'h67};
        dep = !(oa inside {7'h63, 7'h23}) && rd != 0 &&
              (b[19:15] == rd || b[24:20] == rd);
        mm = (oa inside {7'h03, 7'h23}) && (ob inside {7'h03, 7'h23});
        return !(ctl || dep || mm);
    endfunction

    function automatic void model_step(input logic r, input logic f,
                                       input logic s, input logic v,
                                       input logic [31:0] w);
        int sz;
        sz = mq.size();
        if (r || f) begin
            mq.delete();
            ma = NOP; mb = NOP; mva = 0; mvb = 0;
        end else begin
            if (!s) begin
                if (sz == 0) begin
                    ma = NOP; mb = NOP; mva = 0; mvb = 0;
                end else if (sz >= 2 && may_pair(mq[0], mq[1])) begin
                    ma = mq.pop_front(); mb = mq.pop_front(); mva = 1; mvb = 1;
                end else begin
                    ma = mq.pop_front(); mb = NOP; mva = 1; mvb = 0;
                end
            end
            if (v && sz < DEPTH) mq.push_back(w);
        end
    endfunction

    task automatic cyc(input logic r, input logic f, input logic s,
                       input logic v, input logic [31:0] w);
        rst = r; flush = f; stall = s; in_valid = v; in_instr = w;
        @(posedge clk);
        model_step(r, f, s, v, w);
        #1;
    endtask

    function automatic logic [31:0] rand_word();
        logic [6:0] ops [8] = '{7'h13, 7'h33, 7'h03, 7'h23,
                                7'h63, 7'h6f, 7'h67, 7'h37};
        logic [31:0] w;
        w = $urandom;
        w[6:0]   = ops[$urandom_range(0, 7)];
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    task automatic test_reset();
        cyc(1, 1, 1, 1, 32'hdead_beef);
        n_cmp++; if (occupancy !== 4'd0) begin n_err++; $display("FAIL reset_occ got %0d want 0", occupancy); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", in_ready); end
        n_cmp++; if (instrA !== NOP || instrB !== NOP) begin n_err++; $display("FAIL reset_instr got %h/%h want %h/%h", instrA, instrB, NOP, NOP); end
        n_cmp++; if (validA !== 1'b0 || validB !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b%b want 00", validA, validB); end
    endtask

    task automatic test_latency();
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 32'h0030_0193);
        n_cmp++; if (validA !== 1'b0) begin n_err++; $display("FAIL lat_early got %b want 0", validA); end
        cyc(0, 0, 0, 0, 0);
        n_cmp++; if (validA !== 1'b1 || instrA !== 32'h0030_0193) begin n_err++; $display("FAIL lat_issue got %b %h want 1 00300193", validA, instrA); end
        n_cmp++; if (occupancy !== 4'd0) begin n_err++; $display("FAIL lat_occ got %0d want 0", occupancy); end
    endtask

    task automatic test_pair();
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 32'h0050_0093);
        cyc(0, 0, 1, 1, 32'h00A0_0113);
        n_cmp++; if (occupancy !== 4'd2) begin n_err++; $display("FAIL pair_occ_pre got %0d want 2", occupancy); end
        cyc(0, 0, 0, 0, 0);
        n_cmp++; if (validA !== 1'b1 || validB !== 1'b1) begin n_err++; $display("FAIL pair_valid got %b%b want 11", validA, validB); end
        n_cmp++; if (instrA !== 32'h0050_0093 || instrB !== 32'h00A0_0113) begin n_err++; $display("FAIL pair_instr got %h/%h want 00500093/00a00113", instrA, instrB); end
        n_cmp++; if (occupancy !== 4'd0) begin n_err++; $display("FAIL pair_occ_post got %0d want 0", occupancy); end
        cyc(0, 0, 0, 0, 0);
        n_cmp++; if (validA !== 1'b0 || instrA !== NOP) begin n_err++; $display("FAIL pair_empty got %b %h want 0 %h", validA, instrA, NOP); end
    endtask

    task automatic test_split(input string nm, input logic [31:0] a,
                              input logic [31:0] b);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, a);
        cyc(0, 0, 1, 1, b);
        cyc(0, 0, 0, 0, 0);
        n_cmp++; if (validA !== 1'b1 || instrA !== a) begin n_err++; $display("FAIL %s_c1a got %b %h want 1 %h", nm, validA, instrA, a); end
        n_cmp++; if (validB !== 1'b0 || instrB !== NOP) begin n_err++; $display("FAIL %s_c1b got %b %h want 0 %h", nm, validB, instrB, NOP); end
        n_cmp++; if (occupancy !== 4'd1) begin n_err++; $display("FAIL %s_occ got %0d want 1", nm, occupancy); end
        cyc(0, 0, 0, 0, 0);
        n_cmp++; if (validA !== 1'b1 || instrA !== b) begin n_err++; $display("FAIL %s_c2a got %b %h want 1 %h", nm, validA, instrA, b); end
    endtask

    task automatic test_x0_pair();
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 32'h0010_0013);
        cyc(0, 0, 1, 1, 32'h0000_0093);
        cyc(0, 0, 0, 0, 0);
        n_cmp++; if (validA !== 1'b1 || validB !== 1'b1) begin n_err++; $display("FAIL x0_valid got %b%b want 11", validA, validB); end
        n_cmp++; if (instrB !== 32'h0000_0093) begin n_err++; $display("FAIL x0_instrB got %h want 00000093", instrB); end
    endtask

    task automatic test_full();
        logic [31:0] w;
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            w = 32'h0000_0063;
            w[11:7] = 5'(i + 1);
            cyc(0, 0, 1, 1, w);
            if (i == 7) begin
                n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got %b want 0", in_ready); end
            end
        end
        n_cmp++; if (occupancy !== 4'd8) begin n_err++; $display("FAIL full_occ got %0d want 8", occupancy); end
        for (int i = 0; i < 8; i++) begin
            w = 32'h0000_0063;
            w[11:7] = 5'(i + 1);
            cyc(0, 0, 0, 0, 0);
            if (i == 0) begin
                n_cmp++; if (in_ready !== 1'b1 || occupancy !== 4'd7) begin n_err++; $display("FAIL full_pop1 got %b %0d want 1 7", in_ready, occupancy); end
            end
            n_cmp++; if (validA !== 1'b1 || instrA !== w || validB !== 1'b0) begin n_err++; $display("FAIL full_drain%0d got %b %h %b want 1 %h 0", i, validA, instrA, validB, w); end
        end
        n_cmp++; if (occupancy !== 4'd0) begin n_err++; $display("FAIL full_empty got %0d want 0", occupancy); end
    endtask

    task automatic test_flush();
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 32'h0010_0093);
        cyc(0, 0, 0, 1, 32'h0020_0113);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 32'h0030_0193 + (i << 20));
        n_cmp++; if (occupancy !== 4'd5) begin n_err++; $display("FAIL flush_occ_pre got %0d want 5", occupancy); end
        n_cmp++; if (validA !== 1'b1 || instrA !== 32'h0010_0093) begin n_err++; $display("FAIL stall_hold got %b %h want 1 00100093", validA, instrA); end
        cyc(0, 1, 1, 1, 32'h0050_0093);
        n_cmp++; if (occupancy !== 4'd0 || validA !== 1'b0 || validB !== 1'b0) begin n_err++; $display("FAIL flush_now got %0d %b%b want 0 00", occupancy, validA, validB); end
        n_cmp++; if (instrA !== NOP || instrB !== NOP) begin n_err++; $display("FAIL flush_instr got %h/%h want %h/%h", instrA, instrB, NOP, NOP); end
        cyc(0, 0, 0, 0, 0);
        n_cmp++; if (occupancy !== 4'd0 || validA !== 1'b0) begin n_err++; $display("FAIL flush_discard got %0d %b want 0 0", occupancy, validA); end
    endtask

    task automatic test_random();
        int sp;
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            sp = ((i / 250) % 2 == 1) ? 70 : 20;
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 39) == 0,
                $urandom_range(0, 99) < sp, $urandom_range(0, 9) < 7,
                rand_word());
            n_cmp++; if (occupancy !== 4'(mq.size())) begin n_err++; $display("FAIL rnd_occ cyc %0d got %0d want %0d", i, occupancy, mq.size()); end
            n_cmp++; if (in_ready !== (mq.size() < DEPTH)) begin n_err++; $display("FAIL rnd_ready cyc %0d got %b want %b", i, in_ready, mq.size() < DEPTH); end
            n_cmp++; if (validA !== mva || instrA !== ma) begin n_err++; $display("FAIL rnd_A cyc %0d got %b %h want %b %h", i, validA, instrA, mva, ma); end
            n_cmp++; if (validB !== mvb || instrB !== mb) begin n_err++; $display("FAIL rnd_B cyc %0d got %b %h want %b %h", i, validB, instrB, mvb, mb); end
        end
    endtask

    initial begin
        clk = 0; rst = 0; flush = 0; stall = 0; in_valid = 0; in_instr = 0;
        test_reset();
        test_latency();
        test_pair();
        test_split("raw", 32'h0010_0093, 32'h0010_8133);
        test_split("br", 32'h0020_8463, 32'h0010_0093);
        test_split("mem", 32'h0000_2183, 32'h0041_2023);
        test_x0_pair();
        test_full();
        test_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
